uart_threshold_bank: RTL and testbench

Parametrised threshold register bank driven by single-byte UART commands; the successor to the fixed nine-threshold controller. It holds NUM_CH signed thresholds, each with its own default, minimum, maximum and step. It adds saturating steps, per-channel and global restore-to-default, value readback over TX, and an overrun counter. It sits between a byte-level UART core (rx strobe in, tx start/idle handshake out) and the control logic that consumes the thresholds.

---
 rtl/uart_threshold_bank_if.sv | 27 ++
 rtl/uart_threshold_bank.sv | 153 +++++++++++++++
 tb/tb_uart_threshold_bank.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_threshold_bank_if.sv
// Byte-level UART handshake plus threshold/status outputs of uart_threshold_bank.
// master drives the rx side and tx_idle; slave is the bank itself.
interface uart_threshold_bank_if #(
  parameter int unsigned NUM_CH = 9,
  parameter int unsigned WIDTH  = 16
);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    tx_idle;
  logic                    tx_start;
  logic [7:0]              tx_data;
  logic [NUM_CH*WIDTH-1:0] th_flat;
  logic [SelW-1:0]         sel_ch;
  logic [7:0]              drop_cnt;

  modport master (
    output rx_data, rx_valid, tx_idle,
    input  tx_start, tx_data, th_flat, sel_ch, drop_cnt
  );

  modport slave (
    input  rx_data, rx_valid, tx_idle,
    output tx_start, tx_data, th_flat, sel_ch, drop_cnt
  );
endinterface

// File: rtl/uart_threshold_bank.sv
// Bank of NUM_CH signed thresholds adjusted by single-byte UART commands, with
// echo, big-endian readback, saturating steps and a dropped-byte counter.
module uart_threshold_bank #(
  parameter int unsigned NUM_CH = 9,
  parameter int unsigned WIDTH  = 16,
  parameter logic [NUM_CH*WIDTH-1:0] DEF_VALS = {
    16'sd16, 16'sd35, 16'sd16, 16'sd35, 16'sd16, 16'sd35, 16'sd16, 16'sd35, 16'sd2550},
  parameter logic [NUM_CH*WIDTH-1:0] MIN_VALS = {
    -16'sd12, 16'sd32, -16'sd12, 16'sd32, -16'sd12, 16'sd32, -16'sd12, 16'sd32, 16'sd50},
  parameter logic [NUM_CH*WIDTH-1:0] MAX_VALS = {
    16'sd27, 16'sd50, 16'sd27, 16'sd50, 16'sd27, 16'sd50, 16'sd27, 16'sd50, 16'sd5000},
  parameter logic [NUM_CH*WIDTH-1:0] STEP_VALS = {
    16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd1, 16'sd50}
) (
  input logic                  i_clk,
  input logic                  i_rst,
  uart_threshold_bank_if.slave io_bus
);
  localparam int unsigned NB   = (WIDTH + 7) / 8;
  localparam int unsigned ExtW = NB * 8;
  localparam int unsigned BufW = ExtW + 8;
  localparam int unsigned AW   = WIDTH + 1;
  localparam int unsigned CntW = $clog2(NB + 2);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] ChFirst = 8'h41;
  localparam logic [7:0] ChLast  = 8'(65 + NUM_CH - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGuard} state_e;

  state_e                  r_state, w_state_d;
  logic [NUM_CH*WIDTH-1:0] r_th, w_th_d;
  logic [SelW-1:0]         r_sel, w_sel_d;
  logic [BufW-1:0]         r_buf, w_buf_d;
  logic [CntW-1:0]         r_cnt, w_cnt_d;
  logic                    r_guard, w_guard_d;
  logic                    r_tx_start, w_tx_start_d;
  logic [7:0]              r_tx_data, w_tx_data_d;
  logic [7:0]              r_drop, w_drop_d;
  logic                    w_accept;

  logic signed [WIDTH-1:0] w_cur, w_step, w_min, w_max;
  logic signed [WIDTH-1:0] w_up_sat, w_dn_sat;
  logic signed [WIDTH:0]   w_up, w_dn;
  logic signed [ExtW-1:0]  w_ext;

  assign w_cur  = r_th[r_sel*WIDTH +: WIDTH];
  assign w_step = STEP_VALS[r_sel*WIDTH +: WIDTH];
  assign w_min  = MIN_VALS[r_sel*WIDTH +: WIDTH];
  assign w_max  = MAX_VALS[r_sel*WIDTH +: WIDTH];

  // One extra bit of headroom so the step can never wrap before clamping.
  assign w_up     = AW'(w_cur) + AW'(w_step);
  assign w_dn     = AW'(w_cur) - AW'(w_step);
  assign w_up_sat = (w_up > AW'(w_max)) ? w_max : w_up[WIDTH-1:0];
  assign w_dn_sat = (w_dn < AW'(w_min)) ? w_min : w_dn[WIDTH-1:0];
  assign w_ext    = ExtW'(w_cur);

  always_comb begin
    w_state_d    = r_state;
    w_th_d       = r_th;
    w_sel_d      = r_sel;
    w_buf_d      = r_buf;
    w_cnt_d      = r_cnt;
    w_guard_d    = r_guard;
    w_tx_start_d = 1'b0;
    w_tx_data_d  = r_tx_data;
    w_drop_d     = r_drop;
    w_accept     = 1'b0;

    case (r_state)
      StIdle: begin
        if (io_bus.rx_valid) begin
          w_accept = 1'b1;
          w_buf_d  = {io_bus.rx_data, {(BufW-8){1'b0}}};
          w_cnt_d  = CntW'(1);
          if (io_bus.rx_data >= ChFirst && io_bus.rx_data <= ChLast) begin
            w_sel_d = SelW'(io_bus.rx_data - ChFirst);
          end else begin
            case (io_bus.rx_data)
              "w": w_th_d[r_sel*WIDTH +: WIDTH] = w_up_sat;
              "s": w_th_d[r_sel*WIDTH +: WIDTH] = w_dn_sat;
              "d": w_th_d[r_sel*WIDTH +: WIDTH] = DEF_VALS[r_sel*WIDTH +: WIDTH];
              "R": w_th_d = DEF_VALS;
              "?": begin
                w_buf_d = {w_ext, 8'h0A};
                w_cnt_d = CntW'(NB + 1);
              end
              default: begin
                w_accept = 1'b0;
                w_buf_d  = r_buf;
                w_cnt_d  = r_cnt;
              end
            endcase
          end
          if (w_accept) w_state_d = StSend;
        end
      end
      StSend: begin
        if (io_bus.tx_idle) begin
          w_tx_start_d = 1'b1;
          w_tx_data_d  = r_buf[BufW-1 -: 8];
          w_buf_d      = r_buf << 8;
          w_cnt_d      = r_cnt - CntW'(1);
          w_guard_d    = 1'b0;
          w_state_d    = StGuard;
        end
      end
      StGuard: begin
        // First guard cycle ignores tx_idle so the UART has time to drop it.
        if (!r_guard) begin
          w_guard_d = 1'b1;
        end else if (io_bus.tx_idle) begin
          w_state_d = (r_cnt != '0) ? StSend : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase

    if (r_state != StIdle && io_bus.rx_valid && r_drop != 8'hFF) begin
      w_drop_d = r_drop + 8'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_th       <= DEF_VALS;
      r_sel      <= '0;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_guard    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_drop     <= 8'h00;
    end else begin
      r_state    <= w_state_d;
      r_th       <= w_th_d;
      r_sel      <= w_sel_d;
      r_buf      <= w_buf_d;
      r_cnt      <= w_cnt_d;
      r_guard    <= w_guard_d;
      r_tx_start <= w_tx_start_d;
      r_tx_data  <= w_tx_data_d;
      r_drop     <= w_drop_d;
    end
  end

  assign io_bus.tx_start = r_tx_start;
  assign io_bus.tx_data  = r_tx_data;
  assign io_bus.th_flat  = r_th;
  assign io_bus.sel_ch   = r_sel;
  assign io_bus.drop_cnt = r_drop;
endmodule

// File: tb/tb_uart_threshold_bank.sv
// Bench for uart_threshold_bank: directed scenarios plus random commands, all
// checked every cycle against a command-level model of the bank.
module tb_uart_threshold_bank;
  localparam int NUM_CH = 9;
  localparam int WIDTH  = 16;
  localparam int TW     = NUM_CH * WIDTH;
  localparam logic [TW-1:0] DefFlat = 144'h0010_0023_0010_0023_0010_0023_0010_0023_09F6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_threshold_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) io ();

  uart_threshold_bank #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(io)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-channel parameters from their rules: ch0 special, odd vs even others.
  function automatic int def_of(int i);  return (i == 0) ? 2550 : ((i % 2) ? 35 : 16);  endfunction
  function automatic int min_of(int i);  return (i == 0) ? 50 : ((i % 2) ? 32 : -12);   endfunction
  function automatic int max_of(int i);  return (i == 0) ? 5000 : ((i % 2) ? 50 : 27);  endfunction
  function automatic int step_of(int i); return (i == 0) ? 50 : 1;                      endfunction

  // Command-level model state.
  int         mdl_val[NUM_CH];
  int         mdl_sel, mdl_drop;
  bit         mdl_on, mdl_busy, all_sent, prev_idle;
  int         cyc, last_start, ready_cyc;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];

  function automatic logic [TW-1:0] pack_vals();
    logic [TW-1:0] p;
    for (int i = 0; i < NUM_CH; i++) p[i*WIDTH +: WIDTH] = mdl_val[i][WIDTH-1:0];
    return p;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < NUM_CH; i++) mdl_val[i] = def_of(i);
    mdl_sel  = 0;
    mdl_drop = 0;
    mdl_busy = 0;
    all_sent = 0;
    exp_q.delete();
  endtask

  task automatic mdl_accept(input logic [7:0] b);
    int v, k;
    bit acc;
    v   = mdl_val[mdl_sel];
    k   = mdl_sel;
    acc = 1;
    if (int'(b) >= 65 && int'(b) < 65 + NUM_CH) mdl_sel = int'(b) - 65;
    else case (b)
      "w": mdl_val[k] = (v + step_of(k) > max_of(k)) ? max_of(k) : v + step_of(k);
      "s": mdl_val[k] = (v - step_of(k) < min_of(k)) ? min_of(k) : v - step_of(k);
      "d": mdl_val[k] = def_of(k);
      "R": for (int i = 0; i < NUM_CH; i++) mdl_val[i] = def_of(i);
      "?": ;
      default: acc = 0;
    endcase
    if (acc) begin
      if (b == "?") begin
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(b);
      end
      mdl_busy  = 1;
      all_sent  = 0;
      ready_cyc = cyc + 2;
    end
  endtask

  // Compare process: check this cycle's outputs, then advance the model.
  always @(negedge clk) begin
    logic [7:0] eb;
    cyc++;
    if (mdl_on) begin
      chk("th_flat", io.th_flat, pack_vals());
      chk("sel_ch", TW'(io.sel_ch), TW'(mdl_sel));
      chk("drop_cnt", TW'(io.drop_cnt), TW'(mdl_drop));
      if (exp_q.size() == 0) begin
        chk("tx_start_spurious", TW'(io.tx_start), '0);
      end else if (io.tx_start === 1'b1) begin
        eb = exp_q.pop_front();
        chk("tx_data", TW'(io.tx_data), TW'(eb));
        chk("tx_timing", TW'(cyc >= ready_cyc && prev_idle), TW'(1));
        ready_cyc  = cyc + 3;
        last_start = cyc;
        if (exp_q.size() == 0) all_sent = 1;
      end
      if (io.tx_start === 1'b1) tx_log.push_back(io.tx_data);
    end
    if (rst) begin
      mdl_reset();
      mdl_on = 1;
    end else if (mdl_on) begin
      if (mdl_busy) begin
        if (io.rx_valid && mdl_drop < 255) mdl_drop++;
        if (all_sent && cyc > last_start && io.tx_idle) mdl_busy = 0;
      end else if (io.rx_valid) begin
        mdl_accept(io.rx_data);
      end
    end
    prev_idle = io.tx_idle;
  end

  // Simple UART emulation: idle drops for uart_lat cycles after each tx_start.
  int uart_lat = 0;
  int tx_busy  = 0;
  bit hold     = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (io.tx_start === 1'b1) tx_busy = uart_lat;
    else if (tx_busy > 0) tx_busy--;
    io.tx_idle = !hold && tx_busy == 0;
  endtask

  task automatic send_raw(input logic [7:0] b);
    io.rx_valid = 1'b1;
    io.rx_data  = b;
    tick();
    io.rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (mdl_busy && n < 2000) begin
      tick();
      n++;
    end
    if (mdl_busy) chk("idle_timeout", TW'(mdl_busy), '0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    wait_idle();
    send_raw(b);
  endtask

  function automatic logic [7:0] log_at(int i);
    return (i < tx_log.size()) ? tx_log[i] : 8'hxx;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [7:0] b;
    io.rx_valid = 1'b0;
    io.rx_data  = 8'h00;
    io.tx_idle  = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Readback of the reset value of ch0.
    base = tx_log.size();
    send_byte("?");
    wait_idle();
    chk("rb_reset_len", TW'(tx_log.size() - base), TW'(3));
    chk("rb_reset_b0", TW'(log_at(base)), TW'(8'h09));
    chk("rb_reset_b1", TW'(log_at(base + 1)), TW'(8'hF6));
    chk("rb_reset_b2", TW'(log_at(base + 2)), TW'(8'h0A));
    chk("drop_reset", TW'(io.drop_cnt), '0);

    // Saturate ch0 upward.
    base = tx_log.size();
    repeat (60) send_byte("w");
    wait_idle();
    n = 0;
    for (int i = base; i < tx_log.size(); i++) if (tx_log[i] == 8'h77) n++;
    chk("w_echo_cnt", TW'(n), TW'(60));
    chk("ch0_max", TW'(io.th_flat[15:0]), TW'(16'd5000));
    base = tx_log.size();
    send_byte("?");
    wait_idle();
    chk("rb_max_b0", TW'(log_at(base)), TW'(8'h13));
    chk("rb_max_b1", TW'(log_at(base + 1)), TW'(8'h88));
    chk("rb_max_b2", TW'(log_at(base + 2)), TW'(8'h0A));
    send_byte("R");

    // Saturate ch2 downward.
    send_byte("C");
    repeat (30) send_byte("s");
    wait_idle();
    chk("sel_c", TW'(io.sel_ch), TW'(2));
    chk("ch2_min", TW'(io.th_flat[47:32]), TW'(16'hFFF4));
    base = tx_log.size();
    send_byte("?");
    wait_idle();
    chk("rb_min_b0", TW'(log_at(base)), TW'(8'hFF));
    chk("rb_min_b1", TW'(log_at(base + 1)), TW'(8'hF4));
    chk("rb_min_b2", TW'(log_at(base + 2)), TW'(8'h0A));
    chk("ch0_kept", TW'(io.th_flat[15:0]), TW'(16'd2550));

    // Bytes arriving while the echo is stalled are dropped.
    base = tx_log.size();
    hold = 1;
    io.tx_idle = 1'b0;
    send_byte("w");
    repeat (2) tick();
    send_raw("w");
    send_raw("J");
    repeat (15) tick();
    chk("stall_no_tx", TW'(tx_log.size() - base), '0);
    hold = 0;
    tick();
    wait_idle();
    chk("stall_drop", TW'(io.drop_cnt), TW'(2));
    chk("stall_one_step", TW'(io.th_flat[47:32]), TW'(16'hFFF5));
    chk("stall_echo_len", TW'(tx_log.size() - base), TW'(1));
    chk("stall_echo", TW'(log_at(base)), TW'(8'h77));

    // Per-channel default, global restore, out-of-range channel.
    send_byte("s");
    send_byte("d");
    wait_idle();
    chk("ch2_default", TW'(io.th_flat[47:32]), TW'(16'd16));
    send_byte("B");
    send_byte("w");
    send_byte("D");
    send_byte("s");
    send_byte("R");
    wait_idle();
    chk("restore_all", io.th_flat, DefFlat);
    chk("restore_sel", TW'(io.sel_ch), TW'(3));
    base = tx_log.size();
    send_byte("J");
    repeat (10) tick();
    chk("j_no_echo", TW'(tx_log.size() - base), '0);
    chk("j_sel", TW'(io.sel_ch), TW'(3));

    // Reset between first and second readback byte.
    uart_lat = 3;
    base = tx_log.size();
    send_byte("?");
    n = 0;
    while (tx_log.size() == base && n < 100) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_th", io.th_flat, DefFlat);
    chk("rst_sel", TW'(io.sel_ch), '0);
    chk("rst_drop", TW'(io.drop_cnt), '0);
    repeat (20) tick();
    chk("rst_abort_len", TW'(tx_log.size() - base), TW'(1));

    // Reset beats a same-cycle command.
    rst = 1'b1;
    io.rx_valid = 1'b1;
    io.rx_data  = "B";
    tick();
    rst = 1'b0;
    io.rx_valid = 1'b0;
    chk("rst_vs_rx_sel", TW'(io.sel_ch), '0);

    // drop_cnt saturates at 255.
    uart_lat = 0;
    hold = 1;
    io.tx_idle = 1'b0;
    send_byte("?");
    repeat (260) send_raw(8'($urandom_range(0, 255)));
    hold = 0;
    tick();
    wait_idle();
    chk("drop_sat", TW'(io.drop_cnt), TW'(255));

    // Random commands, latencies, drops and resets.
    for (int it = 0; it < 400; it++) begin
      uart_lat = $urandom_range(0, 4);
      case ($urandom_range(0, 9))
        0, 1, 2: b = 8'(65 + $urandom_range(0, 10));
        3, 9:    b = "s";
        4:       b = "w";
        5:       b = "d";
        6:       b = ($urandom_range(0, 3) == 0) ? "R" : "w";
        7:       b = "?";
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 7) == 0) send_raw(b);
      else send_byte(b);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
